// File: rtl/irq_pending_arbiter_pkg.sv
// Shared sizing constants and the delivery FSM state type for the IRQ
// pending arbiter.
package irq_pending_arbiter_pkg;

  localparam int unsigned IRQ_N     = 8;
  localparam int unsigned IRQ_IDX_W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/irq_pending_arbiter_enc.sv
// Combinational N-to-IDX_W lowest-set-bit encoder; sel is 0 when vec is empty.
module lsb_prio_enc #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] sel,
  output logic             any_set
);

  always_comb begin
    sel     = '0;
    any_set = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i] && !any_set) begin
        sel     = IDX_W'(i);
        any_set = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_pending_arbiter.sv
// Captures request rising edges as pending bits and hands the lowest-numbered
// unmasked one to a consumer over a valid/ready handshake.
module irq_pending_arbiter
  import irq_pending_arbiter_pkg::*;
#(
  parameter int unsigned N     = IRQ_N,
  parameter int unsigned IDX_W = IRQ_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic             ready,
  input  logic             clr_ovr,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     pending,
  output logic [N-1:0]     overrun
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [N-1:0]     req_q;
  logic [N-1:0]     rise;
  logic [N-1:0]     cand;
  logic [N-1:0]     clr_vec;
  logic [N-1:0]     pending_nxt;
  logic [N-1:0]     overrun_nxt;
  logic [IDX_W-1:0] sel;
  logic             any_set;
  logic             hs;

  assign rise  = req & ~req_q;
  assign cand  = pending & ~mask;
  assign valid = (state == PRESENT);
  assign hs    = valid && ready;

  lsb_prio_enc #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec     (cand),
    .sel     (sel),
    .any_set (any_set)
  );

  // A same-cycle edge on the delivered line re-arms it instead of flagging overrun.
  always_comb begin
    clr_vec     = hs ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
    pending_nxt = rise | (pending & ~clr_vec);
    overrun_nxt = (rise & pending & ~clr_vec) | (clr_ovr ? '0 : overrun);
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      IDLE: begin
        if (any_set) begin
          idx_nxt   = sel;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      req_q   <= '0;
      pending <= '0;
      overrun <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      req_q   <= req;
      pending <= pending_nxt;
      overrun <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Directed-vector bench: expected delivery indices go into a scoreboard queue
// and a negedge monitor pops one on every completed handshake.
module tb_irq_pending_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ready;
  logic       clr_ovr;
  logic       valid;
  logic [2:0] idx;
  logic [7:0] pending;
  logic [7:0] overrun;

  int checks   = 0;
  int failures = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  irq_pending_arbiter #(
    .N     (8),
    .IDX_W (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .mask    (mask),
    .ready   (ready),
    .clr_ovr (clr_ovr),
    .valid   (valid),
    .idx     (idx),
    .pending (pending),
    .overrun (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Handshake completes at the next rising edge when valid && ready here.
  always @(negedge clk) begin
    if (!rst && valid === 1'b1 && ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got idx %0d expected no delivery at %0t", idx, $time);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (idx !== e) begin
          failures++;
          $display("FAIL sb_idx: got %0d expected %0d at %0t", idx, e, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req = '0; mask = '0; ready = 1'b0; clr_ovr = 1'b0;
    tick(2);
    check("rst_valid",   valid,   0);
    check("rst_idx",     idx,     0);
    check("rst_pending", pending, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    tick(1);

    // Single pulse on line 5
    req = 8'h20; ready = 1'b1; exp_q.push_back(3'd5);
    tick(1);
    req = 8'h00;
    check("t1_pend_set", pending, 8'h20);
    check("t1_valid_e0", valid,   0);
    tick(1);
    check("t1_valid_e1", valid,   1);
    check("t1_idx",      idx,     5);
    tick(1);
    check("t1_pend_clr", pending, 8'h00);
    check("t1_valid_ea", valid,   0);
    ready = 1'b0;

    // Lines 1 and 3 together, consumer stalls
    req = 8'h0A;
    tick(1);
    req = 8'h00;
    check("t2_pend", pending, 8'h0A);
    tick(1);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", valid, 1);
      check("t2_hold_idx",   idx,   1);
      tick(1);
    end
    exp_q.push_back(3'd1); exp_q.push_back(3'd3);
    ready = 1'b1;
    tick(1);
    check("t2_bubble_valid", valid,   0);
    check("t2_bubble_pend",  pending, 8'h08);
    tick(1);
    check("t2_second_valid", valid, 1);
    check("t2_second_idx",   idx,   3);
    tick(1);
    check("t2_pend_empty", pending, 8'h00);
    ready = 1'b0;

    // Masked line 0 is bypassed by line 6
    mask = 8'h01; req = 8'h01;
    tick(1);
    req = 8'h00;
    tick(1);
    check("t3_masked_valid", valid,   0);
    check("t3_masked_pend",  pending, 8'h01);
    req = 8'h40;
    tick(1);
    req = 8'h00;
    tick(1);
    check("t3_idx6", idx, 6);
    exp_q.push_back(3'd6);
    ready = 1'b1;
    tick(1);
    check("t3_pend_after6", pending, 8'h01);
    mask = 8'h00; exp_q.push_back(3'd0);
    tick(1);
    check("t3_idx0", idx, 0);
    tick(1);
    check("t3_pend_empty", pending, 8'h00);
    ready = 1'b0;

    // Overrun on line 2, then clear
    req = 8'h04;
    tick(1);
    req = 8'h00;
    tick(1);
    check("t4_valid", valid, 1);
    req = 8'h04;
    tick(1);
    check("t4_overrun", overrun, 8'h04);
    clr_ovr = 1'b1;
    tick(1);
    clr_ovr = 1'b0;
    check("t4_ovr_clr",  overrun, 8'h00);
    check("t4_pend_kept", pending, 8'h04);
    exp_q.push_back(3'd2);
    ready = 1'b1;
    tick(1);
    check("t4_pend_empty", pending, 8'h00);
    ready = 1'b0; req = 8'h00;
    tick(1);

    // Accept and new edge on line 4 in the same cycle
    req = 8'h10;
    tick(1);
    req = 8'h00;
    tick(1);
    check("t5_idx", idx, 4);
    req = 8'h10; ready = 1'b1;
    exp_q.push_back(3'd4); exp_q.push_back(3'd4);
    tick(1);
    req = 8'h00;
    check("t5_pend_kept", pending, 8'h10);
    check("t5_no_ovr",    overrun, 8'h00);
    check("t5_bubble",    valid,   0);
    tick(1);
    check("t5_repr_valid", valid, 1);
    check("t5_repr_idx",   idx,   4);
    tick(1);
    check("t5_pend_empty", pending, 8'h00);
    ready = 1'b0;

    // Async reset in PRESENT with everything pending
    req = 8'hFF;
    tick(1);
    req = 8'h00;
    tick(1);
    req = 8'hFF;
    tick(1);
    check("t6_pend_full", pending, 8'hFF);
    check("t6_ovr_full",  overrun, 8'hFF);
    check("t6_valid",     valid,   1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid",   valid,   0);
    check("t6_rst_idx",     idx,     0);
    check("t6_rst_pending", pending, 0);
    check("t6_rst_overrun", overrun, 0);
    req = 8'h00;
    tick(1);
    rst = 1'b0;
    tick(2);

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
